// File: rtl/seq_detect_ctrl.sv
// Programmable Mealy serial sequence detector with a valid/ready config port,
// match counting and completion on a programmed match target.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  output logic               cfg_err,
  input  logic               start,
  input  logic               abort,
  input  logic               data,
  input  logic               data_valid,
  output logic               detector,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

  logic [1:0]         state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [CNT_W-1:0]   tgt_q, tgt_d;
  logic               loaded_q, loaded_d;
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic               cfg_fire_s;
  logic               cfg_legal_s;
  logic [MAX_LEN-1:0] window_s;
  logic [MAX_LEN-1:0] mask_s;
  logic               det_s;
  logic [LEN_W-1:0]   fill_inc_s;
  logic [CNT_W:0]     cnt_inc_s;

  assign cfg_ready   = (state_q == IDLE) || (state_q == DONE);
  assign cfg_err     = err_q;
  assign busy        = (state_q == ARMED);
  assign done        = (state_q == DONE);
  assign match_count = cnt_q;
  assign detector    = det_s;

  assign cfg_fire_s  = cfg_valid && cfg_ready;
  assign cfg_legal_s = (cfg_len != {LEN_W{1'b0}}) && (cfg_len <= LEN_MAX);
  // Newest bit sits at window_s[0]; the mask keeps only the low len bits.
  assign window_s    = {hist_q, data};
  assign fill_inc_s  = (fill_q == FILL_MAX) ? fill_q : fill_q + LEN_W'(1);
  assign cnt_inc_s   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  // Pattern-length mask for the comparison window
  always_comb begin
    mask_s = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (LEN_W'(i) < len_q);
    end
  end

  assign det_s = (state_q == ARMED) && data_valid &&
                 (fill_q >= len_q - LEN_W'(1)) &&
                 (((window_s ^ pat_q) & mask_s) == {MAX_LEN{1'b0}});

  // Next-state logic: config handshake, FSM, history/fill and match counting
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    tgt_d    = tgt_q;
    loaded_d = loaded_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;

    if (cfg_fire_s) begin
      if (cfg_legal_s) begin
        pat_d    = cfg_pattern;
        len_d    = cfg_len;
        ovl_d    = cfg_overlap;
        tgt_d    = cfg_target;
        loaded_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      err_d = 1'b0;
    end

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // A config accepted on this edge already counts as loaded.
          if (start && loaded_d) begin
            state_d = ARMED;
            cnt_d   = {CNT_W{1'b0}};
            hist_d  = {(MAX_LEN-1){1'b0}};
            fill_d  = {LEN_W{1'b0}};
          end else begin
            state_d = state_q;
          end
        end
        ARMED: begin
          if (data_valid) begin
            hist_d = window_s[MAX_LEN-2:0];
            if (det_s) begin
              if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_inc_s[CNT_W-1:0];
              end else begin
                cnt_d = cnt_q;
              end
              if (ovl_q) begin
                fill_d = fill_inc_s;
              end else begin
                fill_d = {LEN_W{1'b0}};
              end
              if ((tgt_q != {CNT_W{1'b0}}) && (cnt_inc_s == {1'b0, tgt_q})) begin
                state_d = DONE;
              end else begin
                state_d = ARMED;
              end
            end else begin
              fill_d = fill_inc_s;
            end
          end else begin
            hist_d = hist_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and shadow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pat_q    <= {MAX_LEN{1'b0}};
      len_q    <= {LEN_W{1'b0}};
      ovl_q    <= 1'b0;
      tgt_q    <= {CNT_W{1'b0}};
      loaded_q <= 1'b0;
      hist_q   <= {(MAX_LEN-1){1'b0}};
      fill_q   <= {LEN_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      ovl_q    <= ovl_d;
      tgt_q    <= tgt_d;
      loaded_q <= loaded_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: a behavioural reference model pushes
// expected detector values to a scoreboard that is checked before each edge.
module tb_seq_detect_ctrl;

  logic       clk, rst, cfg_valid, cfg_ready, cfg_overlap, cfg_err;
  logic [7:0] cfg_pattern, cfg_target, match_count;
  logic [4:0] cfg_len;
  logic       start, abort, data, data_valid, detector, busy, done;

  int nchk = 0;
  int nerr = 0;
  logic exp_q[$];

  logic [7:0]  m_pat;
  int          m_len, m_tgt, m_n, m_last, m_cnt;
  bit          m_ovl, m_loaded, m_armed, m_done;
  logic [31:0] m_bits;

  seq_detect_ctrl dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_target(cfg_target), .cfg_err(cfg_err), .start(start), .abort(abort),
    .data(data), .data_valid(data_valid), .detector(detector),
    .match_count(match_count), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_arm();
    m_armed = 1'b1; m_done = 1'b0;
    m_n = 0; m_last = -100; m_cnt = 0; m_bits = 32'd0;
  endtask

  // Reference: a match is the last len bits equal to the pattern, and in
  // non-overlap mode at least len bits after the previous match.
  task automatic model_step(input logic d, output logic hit);
    logic [31:0] w, mask;
    w    = {m_bits[30:0], d};
    mask = (32'd1 << m_len) - 32'd1;
    hit  = (m_n + 1 >= m_len) && (((w ^ {24'd0, m_pat}) & mask) == 32'd0) &&
           (m_ovl || (m_n - m_last >= m_len));
    m_bits = w;
    if (hit) begin
      m_last = m_n;
      if (m_cnt < 255) m_cnt++;
      if (m_tgt != 0 && m_cnt == m_tgt) begin
        m_armed = 1'b0; m_done = 1'b1;
      end
    end
    m_n++;
  endtask

  task automatic cfg_offer(input logic [7:0] p, input logic [4:0] l, input logic o,
                           input logic [7:0] t, input logic st);
    logic legal, rdy;
    rdy   = !m_armed;
    legal = (l >= 5'd1) && (l <= 5'd8);
    @(negedge clk);
    chk("cfg_ready", cfg_ready, rdy);
    cfg_valid = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    cfg_target = t; start = st;
    if (rdy && legal) begin
      m_pat = p; m_len = int'(l); m_ovl = o; m_tgt = int'(t); m_loaded = 1'b1;
    end
    if (rdy && st && m_loaded) model_arm();
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    #1 chk("cfg_err_pulse", cfg_err, rdy && !legal);
    @(negedge clk);
    #1 chk("cfg_err_clear", cfg_err, 1'b0);
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    if (!m_armed && m_loaded) model_arm();
    @(negedge clk);
    start = 1'b0;
    #1 chk("busy_after_start", busy, m_armed);
    if (m_armed) chk("count_cleared", match_count, 8'd0);
  endtask

  task automatic abort_pulse();
    @(negedge clk);
    abort = 1'b1;
    m_armed = 1'b0; m_done = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    #1 chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_count_held", match_count, m_cnt);
  endtask

  task automatic send(input logic b, input logic v);
    logic e;
    @(negedge clk);
    data = b; data_valid = v;
    if (v && m_armed) model_step(b, e);
    else e = 1'b0;
    exp_q.push_back(e);
    #2 chk("detector", detector, exp_q.pop_front());
  endtask

  task automatic send_stream(input logic [16:0] s, input bit gaps);
    for (int i = 0; i < 17; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) send(1'($urandom_range(0, 1)), 1'b0);
      send(s[16-i], 1'b1);
    end
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic chk_count(input string tag, input logic [7:0] exp);
    #1 chk(tag, match_count, exp);
  endtask

  initial begin
    logic [16:0] stream;
    stream = 17'b10100100100111001;
    rst = 1'b1; cfg_valid = 1'b0; cfg_pattern = 8'd0; cfg_len = 5'd0;
    cfg_overlap = 1'b0; cfg_target = 8'd0; start = 1'b0; abort = 1'b0;
    data = 1'b0; data_valid = 1'b0;
    m_loaded = 1'b0; m_armed = 1'b0; m_done = 1'b0;
    m_pat = 8'd0; m_len = 0; m_ovl = 1'b0; m_tgt = 0; m_cnt = 0;
    repeat (2) @(negedge clk);
    #1 chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_detector", detector, 1'b0);
    chk("rst_count", match_count, 8'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    start_pulse();

    cfg_offer(8'b1001, 5'd4, 1'b0, 8'd0, 1'b0);
    start_pulse();
    send_stream(stream, 1'b0);
    chk_count("nonovl_count", 8'd3);
    chk("nonovl_busy", busy, 1'b1);
    abort_pulse();

    cfg_offer(8'b1001, 5'd4, 1'b1, 8'd0, 1'b0);
    start_pulse();
    send_stream(stream, 1'b0);
    chk_count("ovl_count", 8'd4);
    abort_pulse();

    cfg_offer(8'b1001, 5'd4, 1'b1, 8'd2, 1'b0);
    start_pulse();
    send_stream(stream, 1'b0);
    chk_count("target_count", 8'd2);
    chk("target_done", done, 1'b1);
    chk("target_busy", busy, 1'b0);
    chk("target_cfg_ready", cfg_ready, 1'b1);
    start_pulse();

    cfg_offer(8'b0011, 5'd2, 1'b0, 8'd0, 1'b0);
    send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b0, 1'b1); send(1'b1, 1'b1);
    send(1'b1, 1'b1); send(1'b0, 1'b1);
    abort_pulse();
    chk_count("abort_count_value", 8'd1);

    cfg_offer(8'b1001, 5'd4, 1'b0, 8'd0, 1'b0);
    cfg_offer(8'b0011, 5'd0, 1'b1, 8'd1, 1'b0);
    cfg_offer(8'b0011, 5'd9, 1'b1, 8'd1, 1'b0);
    start_pulse();
    send_stream(stream, 1'b1);
    chk_count("gap_count", 8'd3);
    abort_pulse();

    cfg_offer(8'b0000_0001, 5'd1, 1'b1, 8'd0, 1'b1);
    for (int i = 0; i < 24; i++) send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    @(negedge clk);
    data_valid = 1'b0;
    chk_count("len1_count", m_cnt);
    chk("len1_busy", busy, 1'b1);

    @(negedge clk);
    data = 1'b1; data_valid = 1'b1;
    #2 rst = 1'b1;
    m_armed = 1'b0; m_loaded = 1'b0; m_done = 1'b0; m_cnt = 0;
    #1 chk("arst_detector", detector, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_count", match_count, 8'd0);
    chk("arst_cfg_ready", cfg_ready, 1'b1);
    chk("arst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0; data_valid = 1'b0;
    start_pulse();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Programmable controller around a Mealy serial sequence detector. It accepts a pattern, length and overlap mode through a valid/ready configuration port, and is armed by a `start` pulse. While armed it produces a same-cycle Mealy `detector` output on qualified serial input bits, counts matches, and raises `done` when a programmed match target is reached. It sits between a host/config register block and a serial bitstream source, replacing fixed-pattern detectors.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bits (2..16).
- `LEN_W`, 5: width of `cfg_len`; must hold `MAX_LEN`.
- `CNT_W`, 8: width of the match counter and target.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_valid`  in  1  configuration offered.
- `cfg_ready`  out  1  configuration can be accepted (state IDLE or DONE).
- `cfg_pattern`  in  MAX_LEN  pattern; bit `len-1` is the first bit received, bit 0 the last.
- `cfg_len`  in  LEN_W  pattern length, legal range 1..MAX_LEN.
- `cfg_overlap`  in  1  1 = overlapping detection, 0 = non-overlapping.
- `cfg_target`  in  CNT_W  match count that ends the run; 0 = run until abort.
- `cfg_err`  out  1  one-cycle pulse when an illegal `cfg_len` is offered.
- `start`  in  1  arm the detector.
- `abort`  in  1  disarm and return to IDLE.
- `data`  in  1  serial bit.
- `data_valid`  in  1  `data` qualifier.
- `detector`  out  1  Mealy match output, combinational.
- `match_count`  out  CNT_W  matches in the current run.
- `busy`  out  1  state is ARMED.
- `done`  out  1  state is DONE (level).

## Operation
- Registered state: the FSM, the config shadow (pattern, len, overlap, target, cfg_loaded), a MAX_LEN-1 bit history shift register, a fill counter (0..MAX_LEN-1, saturating), and `match_count`.
- FSM states: IDLE, ARMED, DONE. Encoding is free.
- Config handshake: a transfer occurs when `cfg_valid && cfg_ready`.
  - If `cfg_len` is in 1..MAX_LEN, the shadow is loaded and `cfg_loaded` is set.
  - Otherwise the shadow is unchanged and `cfg_err` pulses for 1 cycle.
  - Config offered while ARMED is not accepted; `cfg_ready` = 0.
- IDLE/DONE + `start` + `cfg_loaded` → ARMED. This clears `match_count`, history and fill. `start` without `cfg_loaded` is ignored.
- ARMED, on a cycle with `data_valid`:
  - `detector` = (fill ≥ len-1) && ({history[len-2:0], data} == pattern[len-1:0]).
  - For len = 1, `detector` = (data == pattern[0]).
  - `detector` is 0 whenever the state is not ARMED or `data_valid` = 0.
- Same edge, on a match:
  - `match_count` increments, saturating at 2^CNT_W-1.
  - Non-overlap mode: fill clears to 0. Overlap mode: history shifts normally.
  - If `cfg_target` ≠ 0 and count+1 == `cfg_target`, go to DONE.
- Same edge, no match: history shifts in `data`; fill increments, saturating.
- `abort` takes priority over everything in any state: → IDLE. `match_count` holds its value; the config shadow is kept.
- DONE: `match_count` frozen, `detector` = 0. `start` re-arms; `abort` → IDLE.
- If `start` and `cfg_valid` arrive in the same cycle in IDLE/DONE, the config loads and the run starts with the new config. A legal config sets `cfg_loaded` in the same edge.

## Timing
- Reset values: state IDLE, `cfg_ready` = 1, `cfg_err` = 0, `detector` = 0, `match_count` = 0, `busy` = 0, `done` = 0. Shadow and `cfg_loaded` are cleared.
- `rst` asserted mid-run forces these values asynchronously; no partial match survives.
- `start` → `busy` = 1 on the next cycle. The first qualified bit is sampled one cycle after `start`.
- `detector` has zero latency: it is valid in the same cycle as the final pattern bit, before the edge.
- `match_count` updates 1 cycle after `detector`. `done` rises on the same edge as the terminal count update.
- `data_valid` = 0 cycles are fully transparent: no shift and no fill change.

## Test plan
- Reset/idle: assert `rst` mid-ARMED → all outputs at reset values immediately. `start` without config → `busy` stays 0.
- Non-overlap, pattern 4'b1001, len 4, target 0. Stream 1,0,1,0,0,1,0,0,1,0,0,1,1,1,0,0,1 with `data_valid` held high → `detector` high on bits 5, 11, 16 (0-based); `match_count` = 3.
- Overlap, same pattern and stream → `detector` high on bits 5, 8, 11, 16; `match_count` = 4.
- Target: overlap mode, target 2, same stream → `done` = 1 after the bit-8 edge, `busy` = 0, `detector` = 0 afterwards, `match_count` = 2. Then `start` → count 0, ARMED.
- Config errors/gaps: `cfg_len` = 0 or MAX_LEN+1 → `cfg_err` 1-cycle pulse, previous pattern retained. Config offered while ARMED → `cfg_ready` = 0, not accepted. `data_valid` gaps inserted in the non-overlap stream → identical match positions.
- Abort and len 1: `abort` mid-pattern → IDLE with count held. Len 1, pattern 1 → `detector` = `data` on every valid cycle.
